// File: rtl/pwm_capture.sv
// Purpose: measures an incoming PWM line and recovers its duty code, high time and period.
// Latency: an edge on pwm_in is seen 3 cycles later; results are registered 1 cycle after the closing rise.
// Backpressure: none; valid is a one-cycle pulse that the consumer must take when it appears.
// Optional: define PWM_CAPTURE_PERIOD_CHECK_EN to flag publishes whose period differs from PERIOD.
module pwm_capture #(
  parameter int PERIOD  = 16,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [3:0]       duty_out,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             valid,
  output logic             stuck_high,
  output logic             stuck_low,
  output logic             period_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t          state;
  logic            s1, s2, s3;
  logic            rise, fall;
  logic            timeout_hit;
  logic            pub_norm;
  logic [CNT_W-1:0] hc, pc;
  logic [TW-1:0]   tc;

  // Counters stop at all-ones instead of wrapping so long phases read as "very long".
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) return v;
    else return v + CNT_W'(1);
  endfunction

  // Duty code is high time minus one, pinned to the 4-bit range.
  function automatic logic [3:0] clamp_duty(input logic [CNT_W-1:0] h);
    if (h == '0) return 4'd0;
    else if (h > CNT_W'(16)) return 4'd15;
    else return 4'(h - CNT_W'(1));
  endfunction

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  // An edge in the same cycle as the timeout wins, so the timeout needs a quiet cycle.
  assign timeout_hit = ~rise & ~fall & (tc == TW'(TIMEOUT - 1));
  assign pub_norm = (state == LOW) & rise;

  // Two-flop synchroniser plus a history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Quiet-time counter: cleared by any edge, parks at TIMEOUT so the stuck publish fires once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc <= '0;
    end else if (rise | fall) begin
      tc <= '0;
    end else if (tc != TW'(TIMEOUT)) begin
      tc <= tc + TW'(1);
    end
  end

  // Stuck flags are levels: set by the timeout, dropped by the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else if (rise | fall) begin
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else if (timeout_hit) begin
      stuck_high <= s2;
      stuck_low  <= ~s2;
    end
  end

  // Measurement FSM with registered publish of duty, high time and period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hc         <= '0;
      pc         <= '0;
      duty_out   <= 4'd0;
      high_cnt   <= '0;
      period_cnt <= '0;
      valid      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (timeout_hit) begin
        valid      <= 1'b1;
        period_cnt <= pc;
        duty_out   <= s2 ? 4'd15 : 4'd0;
        high_cnt   <= s2 ? hc : '0;
        hc         <= '0;
        pc         <= '0;
        state      <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state <= HIGH;
              hc    <= CNT_W'(1);
              pc    <= CNT_W'(1);
            end
          end
          HIGH: begin
            pc <= sat_inc(pc);
            if (fall) state <= LOW;
            else      hc    <= sat_inc(hc);
          end
          LOW: begin
            if (rise) begin
              valid      <= 1'b1;
              high_cnt   <= hc;
              period_cnt <= pc;
              duty_out   <= clamp_duty(hc);
              state      <= HIGH;
              hc         <= CNT_W'(1);
              pc         <= CNT_W'(1);
            end else begin
              pc <= sat_inc(pc);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PWM_CAPTURE_PERIOD_CHECK_EN
  // Period check rides along with every publish; stuck publishes always flag an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_err <= 1'b0;
    end else if (timeout_hit) begin
      period_err <= 1'b1;
    end else if (pub_norm) begin
      period_err <= (pc != CNT_W'(PERIOD));
    end
  end
`else
  assign period_err = 1'b0;
  // pub_norm only feeds the optional period check.
  logic unused_pub;
  assign unused_pub = pub_norm;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: duty streams, stuck detection, off-period and mid-period reset.
// Inputs change 1 time unit after the rising edge; outputs are read there or on the falling edge.
// A falling-edge monitor records every valid pulse with its payload and cycle stamp.
module tb_pwm_capture;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 64;

`ifdef PWM_CAPTURE_PERIOD_CHECK_EN
  localparam logic PE_ON = 1'b1;
`else
  localparam logic PE_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pwm_in = 1'b0;
  logic [3:0]       duty_out;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             valid;
  logic             stuck_high;
  logic             stuck_low;
  logic             period_err;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int vcount = 0;
  int last_vcyc = 0;
  int prev_vcyc = 0;
  logic [3:0]       v_duty = 4'd0;
  logic [CNT_W-1:0] v_hc = '0;
  logic [CNT_W-1:0] v_pc = '0;
  logic             v_pe = 1'b0;

  pwm_capture #(.PERIOD(16), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .duty_out   (duty_out),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .valid      (valid),
    .stuck_high (stuck_high),
    .stuck_low  (stuck_low),
    .period_err (period_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid) begin
      vcount++;
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
      v_duty = duty_out;
      v_hc = high_cnt;
      v_pc = period_cnt;
      v_pe = period_err;
    end
  end

  task automatic drive(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gen(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
  endtask

  task automatic apply_reset();
    pwm_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pwm_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({duty_out, high_cnt, period_cnt} !== '0) begin failures++; $display("FAIL reset_data got=%h/%h/%h required=0/0/0", duty_out, high_cnt, period_cnt); end
    checks++; if ({valid, stuck_high, stuck_low, period_err} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b required=0000", {valid, stuck_high, stuck_low, period_err}); end
    rst_n = 1'b1;
  endtask

  task automatic test_duty5();
    int c0;
    apply_reset();
    c0 = vcount;
    gen(6, 10, 3);
    checks++; if (vcount - c0 !== 2) begin failures++; $display("FAIL d5_count got=%0d required=2", vcount - c0); end
    checks++; if (v_duty !== 4'd5) begin failures++; $display("FAIL d5_duty got=%0d required=5", v_duty); end
    checks++; if (v_hc !== 8'd6) begin failures++; $display("FAIL d5_high got=%0d required=6", v_hc); end
    checks++; if (v_pc !== 8'd16) begin failures++; $display("FAIL d5_period got=%0d required=16", v_pc); end
    checks++; if (v_pe !== 1'b0) begin failures++; $display("FAIL d5_perr got=%0d required=0", v_pe); end
    checks++; if (last_vcyc - prev_vcyc !== 16) begin failures++; $display("FAIL d5_spacing got=%0d required=16", last_vcyc - prev_vcyc); end
    checks++; if (duty_out !== 4'd5 || high_cnt !== 8'd6) begin failures++; $display("FAIL d5_hold got=%0d/%0d required=5/6", duty_out, high_cnt); end
  endtask

  task automatic test_duty_switch();
    int c0;
    apply_reset();
    c0 = vcount;
    gen(1, 15, 2);
    checks++; if (vcount - c0 !== 1) begin failures++; $display("FAIL d0_count got=%0d required=1", vcount - c0); end
    checks++; if (v_duty !== 4'd0 || v_hc !== 8'd1 || v_pc !== 8'd16) begin failures++; $display("FAIL d0_vals got=%0d/%0d/%0d required=0/1/16", v_duty, v_hc, v_pc); end
    gen(15, 1, 2);
    checks++; if (vcount - c0 !== 3) begin failures++; $display("FAIL d14_count got=%0d required=3", vcount - c0); end
    checks++; if (v_duty !== 4'd14 || v_hc !== 8'd15 || v_pc !== 8'd16) begin failures++; $display("FAIL d14_vals got=%0d/%0d/%0d required=14/15/16", v_duty, v_hc, v_pc); end
  endtask

  task automatic test_stuck_high();
    int c0;
    apply_reset();
    c0 = vcount;
    gen(8, 8, 1);
    drive(1'b1, 10);
    checks++; if (vcount - c0 !== 1) begin failures++; $display("FAIL sh_first_count got=%0d required=1", vcount - c0); end
    checks++; if (v_duty !== 4'd7 || v_hc !== 8'd8 || v_pc !== 8'd16) begin failures++; $display("FAIL sh_first_vals got=%0d/%0d/%0d required=7/8/16", v_duty, v_hc, v_pc); end
    checks++; if (stuck_high !== 1'b0) begin failures++; $display("FAIL sh_early got=%0d required=0", stuck_high); end
    drive(1'b1, 90);
    checks++; if (stuck_high !== 1'b1 || stuck_low !== 1'b0) begin failures++; $display("FAIL sh_flag got=%0d/%0d required=1/0", stuck_high, stuck_low); end
    checks++; if (vcount - c0 !== 2) begin failures++; $display("FAIL sh_count got=%0d required=2", vcount - c0); end
    checks++; if (v_duty !== 4'd15 || v_hc !== 8'd64 || v_pc !== 8'd64) begin failures++; $display("FAIL sh_vals got=%0d/%0d/%0d required=15/64/64", v_duty, v_hc, v_pc); end
    checks++; if (v_pe !== PE_ON) begin failures++; $display("FAIL sh_perr got=%0d required=%0d", v_pe, PE_ON); end
    drive(1'b0, 5);
    checks++; if (stuck_high !== 1'b0) begin failures++; $display("FAIL sh_clear got=%0d required=0", stuck_high); end
    checks++; if (vcount - c0 !== 2) begin failures++; $display("FAIL sh_after_count got=%0d required=2", vcount - c0); end
  endtask

  task automatic test_stuck_low();
    int c0;
    apply_reset();
    c0 = vcount;
    drive(1'b0, TIMEOUT - 1);
    checks++; if (stuck_low !== 1'b0) begin failures++; $display("FAIL sl_early got=%0d required=0", stuck_low); end
    drive(1'b0, 4);
    checks++; if (stuck_low !== 1'b1 || stuck_high !== 1'b0) begin failures++; $display("FAIL sl_flag got=%0d/%0d required=1/0", stuck_low, stuck_high); end
    checks++; if (vcount - c0 !== 1) begin failures++; $display("FAIL sl_count got=%0d required=1", vcount - c0); end
    checks++; if (v_duty !== 4'd0 || v_hc !== 8'd0 || v_pc !== 8'd0) begin failures++; $display("FAIL sl_vals got=%0d/%0d/%0d required=0/0/0", v_duty, v_hc, v_pc); end
    checks++; if (v_pe !== PE_ON) begin failures++; $display("FAIL sl_perr got=%0d required=%0d", v_pe, PE_ON); end
    drive(1'b0, 100);
    checks++; if (vcount - c0 !== 1 || stuck_low !== 1'b1) begin failures++; $display("FAIL sl_hold got=%0d/%0d required=1/1", vcount - c0, stuck_low); end
  endtask

  task automatic test_period20();
    int c0;
    apply_reset();
    c0 = vcount;
    gen(4, 16, 3);
    checks++; if (vcount - c0 !== 2) begin failures++; $display("FAIL p20_count got=%0d required=2", vcount - c0); end
    checks++; if (v_duty !== 4'd3 || v_hc !== 8'd4 || v_pc !== 8'd20) begin failures++; $display("FAIL p20_vals got=%0d/%0d/%0d required=3/4/20", v_duty, v_hc, v_pc); end
    checks++; if (v_pe !== PE_ON || period_err !== PE_ON) begin failures++; $display("FAIL p20_perr got=%0d/%0d required=%0d", v_pe, period_err, PE_ON); end
    checks++; if (last_vcyc - prev_vcyc !== 20) begin failures++; $display("FAIL p20_spacing got=%0d required=20", last_vcyc - prev_vcyc); end
  endtask

  task automatic test_reset_mid_high();
    int c0;
    apply_reset();
    gen(8, 8, 2);
    drive(1'b1, 6);
    checks++; if (duty_out !== 4'd7 || period_cnt !== 8'd16) begin failures++; $display("FAIL mr_pre got=%0d/%0d required=7/16", duty_out, period_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({duty_out, high_cnt, period_cnt} !== '0 || {valid, stuck_high, stuck_low, period_err} !== 4'b0) begin failures++; $display("FAIL mr_async got=%h/%h/%h/%b required=all zero", duty_out, high_cnt, period_cnt, {valid, stuck_high, stuck_low, period_err}); end
    pwm_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    c0 = vcount;
    gen(8, 8, 1);
    checks++; if (vcount - c0 !== 0) begin failures++; $display("FAIL mr_partial got=%0d required=0", vcount - c0); end
    drive(1'b1, 6);
    checks++; if (vcount - c0 !== 1) begin failures++; $display("FAIL mr_count got=%0d required=1", vcount - c0); end
    checks++; if (v_duty !== 4'd7 || v_hc !== 8'd8 || v_pc !== 8'd16) begin failures++; $display("FAIL mr_vals got=%0d/%0d/%0d required=7/8/16", v_duty, v_hc, v_pc); end
  endtask

  initial begin
    test_reset();
    test_duty5();
    test_duty_switch();
    test_stuck_high();
    test_stuck_low();
    test_period20();
    test_reset_mid_high();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
